// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared tag type and saturation constants for div_sched
// Optional feature macro: DIV_SCHED_DIVZERO_EN
package div_sched_pkg;

    // Wide enough for the largest supported requester count (8)
    localparam int IDX_W = 3;

    // Positive saturation value at 64 bits; narrower widths shift it down
    localparam logic [63:0] SAT_POS_64 = 64'h7FFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
`ifdef DIV_SCHED_DIVZERO_EN
        logic             dz;
        logic             neg;
`endif
    } tag_t;

endpackage

// File: rtl/div_sched_rr_arb.sv
// rtl/div_sched_rr_arb.sv - round-robin arbiter with skip-ineligible and registered priority pointer
module div_sched_rr_arb
    import div_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic             clk,
    input  logic             i_nrst,
    input  logic [NREQ-1:0]  i_req,
    input  logic [NREQ-1:0]  i_elig,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [NREQ-1:0]  w_cand;
    logic [NREQ-1:0]  w_grant;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Two passes: indices at/above the pointer first, then the wrapped-around ones
    always_comb begin
        w_cand  = i_req & i_elig;
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_cand[i] && (IDX_W'(i) >= r_ptr)) begin
                w_found    = 1'b1;
                w_grant[i] = 1'b1;
                w_idx      = IDX_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_cand[i] && (IDX_W'(i) < r_ptr)) begin
                w_found    = 1'b1;
                w_grant[i] = 1'b1;
                w_idx      = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_idx == IDX_W'(NREQ - 1)) ? '0 : w_idx + IDX_W'(1);
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;

endmodule

// File: rtl/div_sched.sv
// rtl/div_sched.sv - credit-limited round-robin scheduler in front of a pipelined divider
// Optional feature macro: DIV_SCHED_DIVZERO_EN (saturate and flag divide-by-zero)
module div_sched
    import div_sched_pkg::*;
#(
    parameter int W       = 32,
    parameter int NREQ    = 4,
    parameter int LAT     = 5,
    parameter int CREDITS = 2
) (
    input  logic              clk,
    input  logic              i_nrst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_num,
    input  logic [NREQ*W-1:0] req_den,
    input  logic              flush,
    output logic [W-1:0]      div_num,
    output logic [W-1:0]      div_den,
    input  logic [W-1:0]      div_quot,
    output logic [NREQ-1:0]   res_valid,
    output logic [W-1:0]      res_quot,
    output logic              res_dz,
    output logic              busy
);

    localparam int CW = $clog2(CREDITS + 1);

    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_grant;
    logic [IDX_W-1:0] w_gidx;
    logic [W-1:0]     w_num;
    logic [W-1:0]     w_den;
    tag_t             w_tag;
    tag_t             w_exit;
    logic             w_busy;

    tag_t             r_issue;
    tag_t             r_pipe [LAT];
    logic [CW-1:0]    r_cred [NREQ];
    logic [W-1:0]     r_num;
    logic [W-1:0]     r_den;
    logic [NREQ-1:0]  r_res_valid;
    logic [W-1:0]     r_res_quot;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = i_nrst && !flush && (r_cred[i] < CW'(CREDITS));
        end
    end

    div_sched_rr_arb #(
        .NREQ(NREQ)
    ) u_arb (
        .clk        (clk),
        .i_nrst     (i_nrst),
        .i_req      (req_valid),
        .i_elig     (w_elig),
        .o_grant    (w_grant),
        .o_grant_idx(w_gidx)
    );

    always_comb begin
        w_num = '0;
        w_den = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_num = req_num[i*W +: W];
                w_den = req_den[i*W +: W];
            end
        end
        w_tag       = '0;
        w_tag.valid = |w_grant;
        w_tag.idx   = w_gidx;
`ifdef DIV_SCHED_DIVZERO_EN
        w_tag.dz    = (w_den == '0);
        w_tag.neg   = w_num[W-1];
`endif
    end

    assign w_exit = r_pipe[LAT-1];

`ifdef DIV_SCHED_DIVZERO_EN
    localparam logic [W-1:0] L_SAT_POS = W'(SAT_POS_64 >> (64 - W));
    localparam logic [W-1:0] L_SAT_NEG = ~L_SAT_POS;
    logic r_res_dz;
`endif

    // r_issue is the tag aligned with div_num/div_den; the pipe tracks the divider's latency
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_issue     <= '0;
            r_num       <= '0;
            r_den       <= '0;
            r_res_valid <= '0;
            r_res_quot  <= '0;
            for (int k = 0; k < LAT; k++) r_pipe[k] <= '0;
            for (int i = 0; i < NREQ; i++) r_cred[i] <= '0;
`ifdef DIV_SCHED_DIVZERO_EN
            r_res_dz    <= 1'b0;
`endif
        end else begin
            if (w_tag.valid) begin
                r_num <= w_num;
                r_den <= w_den;
            end
            r_issue <= w_tag;
            if (flush) begin
                for (int k = 0; k < LAT; k++) r_pipe[k] <= '0;
            end else begin
                r_pipe[0] <= r_issue;
                for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
            end

            r_res_valid <= '0;
            if (!flush && w_exit.valid) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (w_exit.idx == IDX_W'(i)) r_res_valid[i] <= 1'b1;
                end
`ifdef DIV_SCHED_DIVZERO_EN
                r_res_dz   <= w_exit.dz;
                r_res_quot <= w_exit.dz ? (w_exit.neg ? L_SAT_NEG : L_SAT_POS) : div_quot;
`else
                r_res_quot <= div_quot;
`endif
            end

            // A return and an issue in the same cycle cancel out
            for (int i = 0; i < NREQ; i++) begin
                if (flush) begin
                    r_cred[i] <= '0;
                end else if (w_grant[i] && !r_res_valid[i]) begin
                    r_cred[i] <= r_cred[i] + CW'(1);
                end else if (!w_grant[i] && r_res_valid[i]) begin
                    r_cred[i] <= r_cred[i] - CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_busy = r_issue.valid;
        for (int k = 0; k < LAT; k++) w_busy = w_busy | r_pipe[k].valid;
    end

    assign req_ready = w_grant;
    assign div_num   = r_num;
    assign div_den   = r_den;
    assign res_valid = r_res_valid;
    assign res_quot  = r_res_quot;
    assign busy      = w_busy;
`ifdef DIV_SCHED_DIVZERO_EN
    assign res_dz    = r_res_dz;
`else
    assign res_dz    = 1'b0;
`endif

endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - randomized and directed bench for div_sched against a scoreboard model
module tb_div_sched;

    localparam int W       = 32;
    localparam int NREQ    = 4;
    localparam int LAT     = 5;
    localparam int CREDITS = 2;

    logic              clk = 1'b0;
    logic              i_nrst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_num;
    logic [NREQ*W-1:0] req_den;
    logic              flush;
    logic [W-1:0]      div_num;
    logic [W-1:0]      div_den;
    logic [W-1:0]      div_quot;
    logic [NREQ-1:0]   res_valid;
    logic [W-1:0]      res_quot;
    logic              res_dz;
    logic              busy;

    always #5 clk = ~clk;

    div_sched #(.W(W), .NREQ(NREQ), .LAT(LAT), .CREDITS(CREDITS)) dut (
        .clk      (clk),
        .i_nrst   (i_nrst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_num  (req_num),
        .req_den  (req_den),
        .flush    (flush),
        .div_num  (div_num),
        .div_den  (div_den),
        .div_quot (div_quot),
        .res_valid(res_valid),
        .res_quot (res_quot),
        .res_dz   (res_dz),
        .busy     (busy)
    );

    function automatic logic [W-1:0] div_fn(input logic [W-1:0] n, input logic [W-1:0] d);
        longint sn;
        longint sd;
        sn = longint'($signed(n));
        sd = longint'($signed(d));
        if (sd == 0) return '0;
        return W'(sn / sd);
    endfunction

    // External divider: fixed LAT-cycle pipeline
    logic [W-1:0] r_dq [LAT];
    always @(posedge clk) begin
        r_dq[0] <= div_fn(div_num, div_den);
        for (int k = 1; k < LAT; k++) r_dq[k] <= r_dq[k-1];
    end
    assign div_quot = r_dq[LAT-1];

    function automatic logic ref_dz(input logic [W-1:0] d);
`ifdef DIV_SCHED_DIVZERO_EN
        return (d == '0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] n, input logic [W-1:0] d);
        longint lim;
        lim = longint'(1) << (W - 1);
        if (ref_dz(d)) begin
            if ($signed(n) < 0) return W'(-lim);
            return W'(lim - 1);
        end
        return div_fn(n, d);
    endfunction

    typedef struct {
        int           due;
        int           idx;
        logic [W-1:0] q;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           outst[NREQ];
    int           last_grant = -1;
    int           cyc = 0;
    logic [W-1:0] exp_num = '0;
    logic [W-1:0] exp_den = '0;
    int           nvec = 0;
    int           nmis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_cycle();
        exp_t            e;
        logic            have;
        logic [NREQ-1:0] exp_rv;
        int              g;
        int              j;
        if (!i_nrst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_quot", res_quot, 0);
            chk("rst_res_dz", res_dz, 0);
            chk("rst_div_num", div_num, 0);
            chk("rst_div_den", div_den, 0);
            chk("rst_busy", busy, 0);
            sb.delete();
            for (int i = 0; i < NREQ; i++) outst[i] = 0;
            last_grant = -1;
            exp_num = '0;
            exp_den = '0;
        end else begin
            have   = 1'b0;
            exp_rv = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                have = 1'b1;
                exp_rv[e.idx] = 1'b1;
            end
            chk("res_valid", res_valid, exp_rv);
            if (have) begin
                chk("res_quot", res_quot, e.q);
                chk("res_dz", res_dz, e.dz);
            end
            chk("busy", busy, sb.size() > 0);
            chk("div_num", div_num, exp_num);
            chk("div_den", div_den, exp_den);
            g = -1;
            if (!flush) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (last_grant + 1 + k) % NREQ;
                    if (g < 0 && req_valid[j] && outst[j] < CREDITS) g = j;
                end
            end
            chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            if (g >= 0) begin
                exp_num = req_num[g*W +: W];
                exp_den = req_den[g*W +: W];
                sb.push_back('{due: cyc + LAT + 2, idx: g, q: ref_q(exp_num, exp_den), dz: ref_dz(exp_den)});
                outst[g]++;
                last_grant = g;
            end
            if (have) outst[e.idx]--;
            if (flush) begin
                sb.delete();
                for (int i = 0; i < NREQ; i++) outst[i] = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
        req_num[i*W +: W] = n;
        req_den[i*W +: W] = d;
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 2))
            0:       return W'($urandom);
            1:       return W'(int'($urandom_range(0, 200)) - 100);
            default: return W'(int'($urandom_range(0, 100000)) - 50000);
        endcase
    endfunction

    task automatic rand_ops();
        logic [W-1:0] d;
        for (int i = 0; i < NREQ; i++) begin
            d = ($urandom_range(0, 7) == 0) ? '0 : rand_op();
            if ($urandom_range(0, 7) != 0 && d == '0) d = 1;
            set_op(i, rand_op(), d);
        end
    endtask

    task automatic idle();
        req_valid = '0;
        flush     = 1'b0;
    endtask

    initial begin
        i_nrst  = 1'b0;
        req_num = '0;
        req_den = '0;
        idle();
        repeat (3) step();
        i_nrst = 1'b1;
        repeat (2) step();

        // 100 / -7 from requester 1
        set_op(1, 100, -7);
        req_valid = 4'b0010;
        step();
        idle();
        chk("d_num_100", div_num, 100);
        chk("d_den_m7", div_den, 32'hFFFF_FFF9);
        repeat (6) step();
        chk("d_rv1", res_valid, 4'b0010);
        chk("d_q_m14", res_quot, 32'hFFFF_FFF2);
        repeat (2) step();

        // all requesters continuously valid
        req_valid = '1;
        repeat (30) begin
            rand_ops();
            step();
        end
        idle();
        repeat (LAT + 3) step();

        // divide by zero, both signs
        set_op(2, -5, 0);
        req_valid = 4'b0100;
        step();
        set_op(3, 5, 0);
        req_valid = 4'b1000;
        step();
        idle();
        repeat (5) step();
`ifdef DIV_SCHED_DIVZERO_EN
        chk("dz_neg_q", res_quot, 32'h8000_0000);
        chk("dz_neg_flag", res_dz, 1);
        step();
        chk("dz_pos_q", res_quot, 32'h7FFF_FFFF);
        chk("dz_pos_flag", res_dz, 1);
`else
        chk("dz_neg_flag", res_dz, 0);
        step();
        chk("dz_pos_flag", res_dz, 0);
`endif
        repeat (2) step();

        // requester 2 alone: issue coincides with its own return
        req_valid = 4'b0100;
        repeat (16) begin
            rand_ops();
            step();
        end
        idle();
        repeat (LAT + 3) step();

        // flush with three in flight
        rand_ops();
        req_valid = 4'b0111;
        repeat (3) step();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (LAT + 2) step();
        chk("flush_busy", busy, 0);
        chk("flush_rv", res_valid, 0);
        req_valid = '1;
        repeat (4) step();
        idle();
        repeat (LAT + 3) step();

        // reset with two in flight
        rand_ops();
        req_valid = 4'b0011;
        repeat (2) step();
        idle();
        i_nrst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_num", div_num, 0);
        repeat (2) step();
        i_nrst = 1'b1;
        repeat (20) step();

        // random traffic with occasional flush
        repeat (400) begin
            rand_ops();
            req_valid = NREQ'($urandom);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        idle();
        repeat (LAT + 3) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter W, default 32, operand and quotient width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter LAT, default 5, clock cycles from div_num/div_den valid to div_quot valid on the external pipelined divider (1..32).
REQ-004 Parameter CREDITS, default 2, maximum in-flight operations per requester (1..LAT+2).
REQ-005 clk  in  1  single clock; every register SHALL be clocked on its rising edge.
REQ-006 i_nrst  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  NREQ  per-requester operation request.
REQ-008 req_ready  out  NREQ  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-009 req_num  in  NREQ*W  signed numerators, requester i at bits [i*W +: W].
REQ-010 req_den  in  NREQ*W  signed denominators, same packing.
REQ-011 flush  in  1  synchronous discard of all in-flight operations.
REQ-012 div_num  out  W  registered numerator to the divider.
REQ-013 div_den  out  W  registered denominator to the divider.
REQ-014 div_quot  in  W  divider quotient.
REQ-015 res_valid  out  NREQ  one-hot, one-cycle result strobe per requester.
REQ-016 res_quot  out  W  shared registered quotient bus.
REQ-017 res_dz  out  1  divide-by-zero flag qualifying res_quot.
REQ-018 busy  out  1  high while any operation is in flight.

Function
REQ-019 At most one transfer SHALL occur per cycle; req_ready SHALL be one-hot or zero.
REQ-020 Arbitration SHALL be round-robin: highest priority is given to the index one above the last granted index, wrapping from NREQ-1 to 0; after reset, index 0 has highest priority.
REQ-021 req_ready[i] SHALL be high only when requester i wins arbitration, its credit counter is below CREDITS, and flush is low.
REQ-022 A requester at its credit limit SHALL be skipped, and the grant SHALL pass to the next eligible requester in the same cycle.
REQ-023 The operands of a transfer in cycle T SHALL appear on div_num/div_den in cycle T+1 and SHALL hold until the next transfer.
REQ-024 Each issue SHALL push a {valid, requester index, dz} tag into a LAT-deep shift register; non-issue cycles SHALL push an invalid tag.
REQ-025 When a valid tag exits, div_quot SHALL be registered onto res_quot, and res_valid[index] SHALL pulse in cycle T+LAT+2.
REQ-026 Back-to-back issues SHALL produce back-to-back results in issue order.
REQ-027 Per-requester credit counters SHALL increment on issue and decrement on res_valid; a simultaneous issue and return SHALL leave the count unchanged.
REQ-028 flush SHALL invalidate every tag, clear all credit counters, and suppress res_valid from the next cycle onward; the round-robin pointer SHALL be unaffected.
REQ-029 busy SHALL be the OR of all valid tags plus the issue register.
REQ-030 res_valid SHALL never assert without a prior matching issue.

Reset
REQ-031 While i_nrst is low: req_ready=0, res_valid=0, res_quot=0, res_dz=0, div_num=0, div_den=0, busy=0, all tags invalid, all credits 0, priority pointer=0.
REQ-032 Reset asserted mid-operation SHALL drop all in-flight results silently; no res_valid SHALL follow deassertion without a new issue.

Configuration
REQ-033 With macro DIV_SCHED_DIVZERO_EN defined, den==0 SHALL set the tag dz bit, and the result SHALL be saturated: 2^(W-1)-1 for num>=0, -2^(W-1) for num<0, with res_dz=1.
REQ-034 Without DIV_SCHED_DIVZERO_EN, div_quot SHALL pass unmodified, res_dz SHALL be tied 0, and no dz tag bit SHALL exist.

Structure
REQ-035 A shared package div_sched_pkg SHALL hold the tag struct typedef {valid, idx, dz} and the saturation constants.
REQ-036 Arbitration SHALL be a sub-module div_sched_rr_arb (NREQ request/eligible inputs, one-hot grant output, pointer register).

Verification
REQ-037 W=32, LAT=5: requester 1 issues 100/-7 at cycle 10 -> div_num=100 and div_den=-7 at cycle 11; res_valid[1] at cycle 17 with res_quot=-14.
REQ-038 All 4 requesters valid continuously, CREDITS=2 -> grant order 0,1,2,3,0,... with no requester exceeding 2 outstanding.
REQ-039 Requester 2 issues at cycle T and its result returns at cycle T+7 while it issues again -> credit stays at 1.
REQ-040 DIV_SCHED_DIVZERO_EN defined: -5/0 -> res_quot=0x80000000 and res_dz=1; 5/0 -> 0x7FFFFFFF; macro undefined -> res_dz=0.
REQ-041 Three ops in flight, flush pulsed -> no res_valid, busy=0 within LAT+2 cycles, all credits 0.
REQ-042 i_nrst dropped with two ops in flight -> all outputs 0; after release, no res_valid over 20 idle cycles.
